// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the 7-segment scan controller: segment bit positions,
// the all-dark pattern and the scan FSM state encoding.
package seg_scan_ctrl_pkg;

   localparam int SEG_A  = 7;
   localparam int SEG_B  = 6;
   localparam int SEG_C  = 5;
   localparam int SEG_D  = 4;
   localparam int SEG_E  = 3;
   localparam int SEG_F  = 2;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;

   localparam logic [7:0] SEG_OFF = 8'hFF;

   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } state_e;

endpackage

// File: rtl/seg_scan_ctrl_bcdmapper.sv
// Combinational nibble to 7-segment decoder, active-high, {a..g,dp}; dp always 0.
// Codes 0xA-0xF decode as hex glyphs A b C d E F.
module bcdmapper (
   input  logic [3:0] bcd_i,
   output logic [7:0] seg_o
);

   always_comb begin
      seg_o = 8'h00;
      unique case (bcd_i)
         4'h0: seg_o = 8'b1111_1100;
         4'h1: seg_o = 8'b0110_0000;
         4'h2: seg_o = 8'b1101_1010;
         4'h3: seg_o = 8'b1111_0010;
         4'h4: seg_o = 8'b0110_0110;
         4'h5: seg_o = 8'b1011_0110;
         4'h6: seg_o = 8'b1011_1110;
         4'h7: seg_o = 8'b1110_0000;
         4'h8: seg_o = 8'b1111_1110;
         4'h9: seg_o = 8'b1111_0110;
         4'hA: seg_o = 8'b1110_1110;
         4'hB: seg_o = 8'b0011_1110;
         4'hC: seg_o = 8'b1001_1100;
         4'hD: seg_o = 8'b0111_1010;
         4'hE: seg_o = 8'b1001_1110;
         4'hF: seg_o = 8'b1000_1110;
         default: seg_o = 8'h00;
      endcase
   end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scanner with dead-time blanking,
// frame-aligned double-buffered display data and leading-zero blanking.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_BLANK | all anodes off, dead time before driving digit idx
// ST_DRIVE | anode idx on, segments show shadow nibble idx
module seg_scan_ctrl
   import seg_scan_ctrl_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int DRIVE_CYCLES = 50000,
   parameter int BLANK_CYCLES = 500,
   localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    lzb_en,
   output logic [7:0]              seg_n,
   output logic [NUM_DIGITS-1:0]   an_n,
   output logic [IDX_W-1:0]        digit_idx,
   output logic                    frame_tick,
   output logic                    load_ack
);

   localparam int MAX_CYC = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam int BUF_W   = 5 * NUM_DIGITS;

   localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

   // Digit k>0 is blank when it and every more-significant nibble are zero.
   function automatic logic [NUM_DIGITS-1:0] lzb_mask(input logic [4*NUM_DIGITS-1:0] v);
      logic                  zero_above;
      logic [NUM_DIGITS-1:0] mask;
      zero_above = 1'b1;
      mask       = '0;
      for (int k = NUM_DIGITS - 1; k > 0; k--) begin
         zero_above = zero_above && (v[4*k +: 4] == 4'h0);
         mask[k]    = zero_above;
      end
      return mask;
   endfunction

   // Reset asserts asynchronously and releases on a clock edge.
   logic [1:0] rst_sync_q;
   logic       rst_int_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= 2'b00;
      else        rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_int_n = rst_sync_q[1];

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [BUF_W-1:0]        staging_q, staging_d;
   logic [BUF_W-1:0]        shadow_q, shadow_d;
   logic                    pending_q, pending_d;
   logic [7:0]              seg_q, seg_d;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic                    ftick_q, ftick_d;
   logic                    ack_q, ack_d;

   logic [4*NUM_DIGITS-1:0] shadow_val;
   logic [NUM_DIGITS-1:0]   shadow_dp;
   logic [3:0]              nibble_sel;
   logic [7:0]              map_seg;
   logic [NUM_DIGITS-1:0]   blank_mask;
   logic [7:0]              lit;
   logic                    wrap;

   assign shadow_val = shadow_q[BUF_W-1:NUM_DIGITS];
   assign shadow_dp  = shadow_q[NUM_DIGITS-1:0];
   assign nibble_sel = shadow_val[4*idx_q +: 4];

   bcdmapper u_bcdmapper (
      .bcd_i (nibble_sel),
      .seg_o (map_seg)
   );

   assign blank_mask = lzb_en ? lzb_mask(shadow_val) : '0;
   assign wrap       = (state_q == ST_DRIVE) && (cnt_q == DRIVE_LAST) && (idx_q == IDX_LAST);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + CNT_W'(1);
      idx_d     = idx_q;
      staging_d = staging_q;
      shadow_d  = shadow_q;
      pending_d = pending_q;
      ftick_d   = 1'b0;
      ack_d     = 1'b0;
      an_d      = '1;
      seg_d     = SEG_OFF;
      lit       = '0;

      unique case (state_q)
         ST_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               state_d = ST_DRIVE;
               cnt_d   = '0;
            end
         end
         ST_DRIVE: begin
            if (cnt_q == DRIVE_LAST) begin
               state_d = ST_BLANK;
               cnt_d   = '0;
               idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end
         end
         default: state_d = ST_BLANK;
      endcase

      // A load that lands on the wrap cycle bypasses staging entirely.
      if (wrap) begin
         ftick_d = 1'b1;
         if (load) begin
            shadow_d  = {value, dp_in};
            pending_d = 1'b0;
            ack_d     = 1'b1;
         end else if (pending_q) begin
            shadow_d  = staging_q;
            pending_d = 1'b0;
            ack_d     = 1'b1;
         end
      end else if (load) begin
         staging_d = {value, dp_in};
         pending_d = 1'b1;
      end

      // idx only moves on DRIVE->BLANK, so idx_q is the digit for any DRIVE next state.
      if (state_d == ST_DRIVE) begin
         lit          = blank_mask[idx_q] ? 8'h00 : map_seg;
         lit[SEG_DP]  = shadow_dp[idx_q];
         seg_d        = ~lit;
         an_d         = ~(NUM_DIGITS'(1) << idx_q);
      end
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q   <= ST_BLANK;
         cnt_q     <= '0;
         idx_q     <= '0;
         staging_q <= '0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
         seg_q     <= SEG_OFF;
         an_q      <= '1;
         ftick_q   <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         staging_q <= staging_d;
         shadow_q  <= shadow_d;
         pending_q <= pending_d;
         seg_q     <= seg_d;
         an_q      <= an_d;
         ftick_q   <= ftick_d;
         ack_q     <= ack_d;
      end
   end

   assign seg_n      = seg_q;
   assign an_n       = an_q;
   assign digit_idx  = idx_q;
   assign frame_tick = ftick_q;
   assign load_ack   = ack_q;

endmodule
